seq_mul4: RTL and testbench
===========================

SEQ_MUL4 -- requirements
Module: seq_mul4

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request to begin a multiply; sampled on rising edge of clk.
REQ-005 Port: a  input  4  unsigned multiplicand; sampled with start.
REQ-006 Port: b  input  4  unsigned multiplier; sampled with start.
REQ-007 Port: busy  output  1  high while a multiply is in progress.
REQ-008 Port: done  output  1  one-cycle pulse marking a new valid product.
REQ-009 Port: p  output  8  unsigned product; registered.

Function
REQ-010 The block SHALL compute p = a * b, unsigned, full 8-bit result with no truncation or overflow.
REQ-011 The block SHALL use a Moore FSM with states IDLE, CALC and DONE.
REQ-012 IDLE: busy=0, done=0; start=1 at a clock edge SHALL capture a, b, clear the accumulator, set the bit counter to 0 and move to CALC.
REQ-013 IDLE with start=0 SHALL remain in IDLE with all registers held.
REQ-014 CALC: busy=1, done=0; each clock SHALL add (a_reg AND replicated b_reg[count]) shifted left by count to the 8-bit accumulator, then increment count.
REQ-015 Count SHALL be 2 bits; the edge that processes count=3 SHALL load p from the final accumulator value and move to DONE.
REQ-016 DONE: busy=0, done=1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-017 Latency: with start sampled at edge N, done SHALL be high between edges N+4 and N+5, and p SHALL be valid from edge N+4.
REQ-018 start SHALL be ignored in CALC and DONE; a and b changes during CALC SHALL NOT affect the result.
REQ-019 p SHALL hold its last value until the next completion; it SHALL NOT change during CALC.
REQ-020 Back-to-back: start held high continuously SHALL begin a new multiply on the edge after DONE, giving one result every 6 cycles.
REQ-021 Operands 0 SHALL take the same 4-cycle latency; there is no early termination.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, count=0, accumulator=0, a_reg=0, b_reg=0, p=0, busy=0, done=0, regardless of clk.
REQ-023 Reset asserted mid-CALC SHALL abandon the operation; no done pulse is issued for it, and p reads 0.
REQ-024 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-025 A shared package SHALL hold the operand width constant (4), the product width constant (8) and the FSM state enumeration.
REQ-026 The partial-product row SHALL be a sub-module named pp_row4, with inputs a[3:0] and bit, and output a[3:0] AND bit; it is instantiated once in seq_mul4.
REQ-027 All state SHALL sit in a single clock domain, with no latches and no combinational path from inputs to outputs.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Reset release, then a=15, b=15, start for 1 cycle -> busy high 4 cycles; done pulses once; p=225 (0xE1).
- a=9, b=6 -> p=54 at edge N+4; done is 1 for exactly one cycle.
- a=0, b=13 -> p=0 after the same 4-cycle latency; done pulses.
- Start a=3, b=5; in CALC, assert start with a=15, b=15 -> second request ignored; p=15; only one done pulse.
- Start a=7, b=7; assert rst_n=0 at edge N+2 -> p=0, busy=0, done=0 immediately; no done afterwards.
- start held high with a=2, b=3 then a=4, b=4 -> results 6 then 16; done pulses 6 cycles apart.

Source files
------------

// File: rtl/seq_mul4_pkg.sv
// seq_mul4_pkg: shared widths and FSM state encoding for the 4x4 sequential multiplier
package seq_mul4_pkg;
  localparam int W = 4;
  localparam int PW = 8;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/seq_mul4_pp_row4.sv
// pp_row4: one partial-product row, the multiplicand gated by a single multiplier bit
module pp_row4
  import seq_mul4_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic         b_bit,
  output logic [W-1:0] row
);
  assign row = a & {W{b_bit}};
endmodule

// File: rtl/seq_mul4.sv
// seq_mul4: shift-and-add 4x4 unsigned multiplier, one multiplier bit per clock
module seq_mul4
  import seq_mul4_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] p
);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [PW-1:0] acc_q, acc_d, p_q, p_d, sum;
  logic [W-1:0] a_q, a_d, b_q, b_d, row;
  pp_row4 u_row (.a(a_q), .b_bit(b_q[cnt_q]), .row(row));
  assign sum = acc_q + (PW'(row) << cnt_q);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    a_d = a_q;
    b_d = b_q;
    p_d = p_q;
    case (state_q)
      IDLE: if (start) begin
        a_d = a;
        b_d = b;
        acc_d = '0;
        cnt_d = '0;
        state_d = CALC;
      end
      CALC: begin
        acc_d = sum;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          p_d = sum;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
    end
  end
  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign p = p_q;
endmodule

// File: tb/tb_seq_mul4.sv
// tb_seq_mul4: scoreboard bench for seq_mul4 with directed scenarios and random operands
module tb_seq_mul4;
  logic clk = 0, rst_n = 1, start = 0;
  logic [3:0] a = 0, b = 0;
  logic busy, done;
  logic [7:0] p;
  int checks = 0, errors = 0, cyc = 0, n;
  logic [7:0] exp_q[$];
  int done_t[$];
  logic [7:0] p_prev = 0;

  seq_mul4 dut (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
                .busy(busy), .done(done), .p(p));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding product
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got p=%0d want no done", p);
      end else chk("product", int'(p), int'(exp_q.pop_front()));
    end
    if (rst_n && busy) chk("p_hold_during_calc", int'(p), int'(p_prev));
    p_prev = p;
  end

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 20 && (busy || done); i++) @(negedge clk);
    if (busy || done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got busy=%0b done=%0b want 0 0", busy, done);
    end
  endtask

  task automatic mul_now(input logic [3:0] x, input logic [3:0] y);
    int lat = 0, bc = 0;
    start = 1;
    a = x;
    b = y;
    @(posedge clk);
    exp_q.push_back(8'(x) * 8'(y));
    #1 start = 0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end
    chk("done_latency", lat, 5);
    chk("busy_cycles", bc, 4);
    @(negedge clk);
    chk("done_pulse_width", int'(done), 0);
  endtask

  task automatic mul(input logic [3:0] x, input logic [3:0] y);
    wait_idle();
    mul_now(x, y);
  endtask

  initial begin
    #2 rst_n = 0;
    #3;
    chk("reset_p", int'(p), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1;
    mul(15, 15);
    mul(9, 6);
    mul(0, 13);
    // second request during CALC must be ignored
    wait_idle();
    n = done_t.size();
    start = 1; a = 3; b = 5;
    @(posedge clk);
    exp_q.push_back(8'(4'd3) * 8'(4'd5));
    #1 a = 15; b = 15;
    repeat (3) @(posedge clk);
    #1 start = 0;
    repeat (10) @(negedge clk);
    chk("ignored_start_dones", done_t.size() - n, 1);
    // reset mid-CALC abandons the multiply
    wait_idle();
    n = done_t.size();
    start = 1; a = 7; b = 7;
    @(posedge clk);
    #1 start = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("midreset_p", int'(p), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1;
    mul_now(12, 11);
    repeat (6) @(negedge clk);
    chk("dones_after_midreset", done_t.size() - n, 1);
    // start held high: back-to-back results six cycles apart
    wait_idle();
    n = done_t.size();
    start = 1; a = 2; b = 3;
    @(posedge clk);
    exp_q.push_back(8'd6);
    #1 a = 4; b = 4;
    repeat (6) @(posedge clk);
    exp_q.push_back(8'd16);
    #1 start = 0;
    repeat (12) @(negedge clk);
    chk("b2b_dones", done_t.size() - n, 2);
    if (done_t.size() >= n + 2) chk("b2b_spacing", done_t[n+1] - done_t[n], 6);
    repeat (25) mul(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
